// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: letter codes, active-low patterns, word ids
// and the reference words used to classify decoded strings.
package seven_seg_pkg;

  localparam int unsigned SEG_W   = 8;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned CHARS_W = 24;

  typedef logic [CODE_W-1:0] char_t;
  typedef enum logic {COLLECT, EMIT} state_t;

  localparam char_t CH_A     = 4'd0;
  localparam char_t CH_K     = 4'd1;
  localparam char_t CH_L     = 4'd2;
  localparam char_t CH_M     = 4'd3;
  localparam char_t CH_N     = 4'd4;
  localparam char_t CH_O     = 4'd5;
  localparam char_t CH_S     = 4'd6;
  localparam char_t CH_T     = 4'd7;
  localparam char_t CH_Y     = 4'd8;
  localparam char_t CH_BLANK = 4'd9;
  localparam char_t CH_BAD   = 4'd15;

  // Active-low patterns, bit7 = dp, bits 6..0 = g..a
  localparam logic [SEG_W-1:0] SEG_A     = 8'h88;
  localparam logic [SEG_W-1:0] SEG_K     = 8'h89;
  localparam logic [SEG_W-1:0] SEG_L     = 8'hC7;
  localparam logic [SEG_W-1:0] SEG_M     = 8'hEA;
  localparam logic [SEG_W-1:0] SEG_N     = 8'hAB;
  localparam logic [SEG_W-1:0] SEG_O     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_S     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_T     = 8'h87;
  localparam logic [SEG_W-1:0] SEG_Y     = 8'h91;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  localparam logic [ID_W-1:0] WORD_UNKNOWN = 2'd0;
  localparam logic [ID_W-1:0] WORD_TOMSK   = 2'd1;
  localparam logic [ID_W-1:0] WORD_NSK     = 2'd2;
  localparam logic [ID_W-1:0] WORD_ASTANA  = 2'd3;

  localparam logic [CHARS_W-1:0] CHARS_BLANK = 24'h999999;
  localparam logic [CHARS_W-1:0] REF_TOMSK   = 24'h975361;
  localparam logic [CHARS_W-1:0] REF_NSK     = 24'h999461;
  localparam logic [CHARS_W-1:0] REF_ASTANA  = 24'h067040;

  function automatic logic [ID_W-1:0] classify(input logic err,
                                               input logic [LEN_W-1:0] len,
                                               input logic [CHARS_W-1:0] chars);
    if (err)                                 return WORD_UNKNOWN;
    if (len == 3'd5 && chars == REF_TOMSK)   return WORD_TOMSK;
    if (len == 3'd3 && chars == REF_NSK)     return WORD_NSK;
    if (len == 3'd6 && chars == REF_ASTANA)  return WORD_ASTANA;
    return WORD_UNKNOWN;
  endfunction

endpackage

// File: rtl/seven_seg_word_decoder_if.sv
// Segment-beat input stream and decoded-word output stream of the word decoder.
interface seven_seg_word_decoder_if;
  import seven_seg_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [SEG_W-1:0]   in_seg;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ID_W-1:0]    out_word_id;
  logic [LEN_W-1:0]   out_len;
  logic [CHARS_W-1:0] out_chars;
  logic               out_error;

  modport master (output in_valid, in_seg, in_last, out_ready,
                  input  in_ready, out_valid, out_word_id, out_len, out_chars, out_error);

  modport slave  (input  in_valid, in_seg, in_last, out_ready,
                  output in_ready, out_valid, out_word_id, out_len, out_chars, out_error);
endinterface

// File: rtl/seven_seg_to_char.sv
// Combinational active-low seven-segment pattern to letter code; unknown patterns give BAD.
module seven_seg_to_char
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output char_t            code_c
);

  always_comb begin
    code_c = CH_BAD;
    case (seg)
      SEG_A:     code_c = CH_A;
      SEG_K:     code_c = CH_K;
      SEG_L:     code_c = CH_L;
      SEG_M:     code_c = CH_M;
      SEG_N:     code_c = CH_N;
      SEG_O:     code_c = CH_O;
      SEG_S:     code_c = CH_S;
      SEG_T:     code_c = CH_T;
      SEG_Y:     code_c = CH_Y;
      SEG_BLANK: code_c = CH_BLANK;
      default:   code_c = CH_BAD;
    endcase
  end

endmodule

// File: rtl/seven_seg_word_decoder.sv
// Collects up to MAX_DIGITS segment beats into a word of letter codes and
// classifies it as TOMSK, NSK, ASTANA or unknown.
module seven_seg_word_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_seg_word_decoder_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   len, len_n;
  logic [CHARS_W-1:0] chars, chars_n;
  logic               err, err_n;
  logic [ID_W-1:0]    id, id_n;
  logic               rdy, rdy_n;
  logic               vld, vld_n;
  char_t              code_c;
  logic               accept_c;

  seven_seg_to_char u_to_char (
    .seg    (bus.in_seg),
    .code_c (code_c)
  );

  assign accept_c = bus.in_valid && rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
      cnt   <= '0;
      len   <= '0;
      chars <= CHARS_BLANK;
      err   <= 1'b0;
      id    <= WORD_UNKNOWN;
      rdy   <= 1'b1;
      vld   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len   <= len_n;
      chars <= chars_n;
      err   <= err_n;
      id    <= id_n;
      rdy   <= rdy_n;
      vld   <= vld_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    chars_n = chars;
    err_n   = err;
    id_n    = id;
    case (state)
      COLLECT: begin
        if (accept_c) begin
          cnt_n = cnt + 1'b1;
          // Blanks before the first letter are padding; later ones are holes in the word
          if (code_c == CH_BAD) begin
            err_n = 1'b1;
          end else if (code_c == CH_BLANK) begin
            if (len != '0) err_n = 1'b1;
          end else begin
            chars_n = {chars[CHARS_W-CODE_W-1:0], code_c};
            len_n   = len + 1'b1;
          end
          if (bus.in_last || cnt == CNT_W'(MAX_DIGITS - 1)) begin
            state_n = EMIT;
            id_n    = classify(err_n, len_n, chars_n);
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          state_n = COLLECT;
          cnt_n   = '0;
          len_n   = '0;
          chars_n = CHARS_BLANK;
          err_n   = 1'b0;
          id_n    = WORD_UNKNOWN;
        end
      end
      default: state_n = COLLECT;
    endcase
    rdy_n = (state_n == COLLECT);
    vld_n = (state_n == EMIT);
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = vld;
  assign bus.out_word_id = id;
  assign bus.out_len     = len;
  assign bus.out_chars   = chars;
  assign bus.out_error   = err;

endmodule

// File: tb/tb_seven_seg_word_decoder.sv
// Directed bench for seven_seg_word_decoder with hand-computed expected words.
module tb_seven_seg_word_decoder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  seven_seg_word_decoder_if bus ();

  seven_seg_word_decoder #(.MAX_DIGITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [7:0] seg, input logic last);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_seg   = seg;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_seg   = 8'hFF;
  endtask

  task automatic check_word(input string tag, input logic [1:0] id, input logic [2:0] len,
                            input logic [23:0] chars, input logic err);
    check({tag, "_valid"}, 32'(bus.out_valid),   32'd1);
    check({tag, "_ready"}, 32'(bus.in_ready),    32'd0);
    check({tag, "_id"},    32'(bus.out_word_id), 32'(id));
    check({tag, "_len"},   32'(bus.out_len),     32'(len));
    check({tag, "_chars"}, 32'(bus.out_chars),   32'(chars));
    check({tag, "_err"},   32'(bus.out_error),   32'(err));
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_take_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_take_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid),   32'd0);
    check({tag, "_id"},    32'(bus.out_word_id), 32'd0);
    check({tag, "_len"},   32'(bus.out_len),     32'd0);
    check({tag, "_chars"}, 32'(bus.out_chars),   32'h999999);
    check({tag, "_err"},   32'(bus.out_error),   32'd0);
  endtask

  initial begin
    logic [7:0] tomsk  [6] = '{8'hFF, 8'h87, 8'hC0, 8'hEA, 8'h92, 8'h89};
    logic [7:0] nsk_pad[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'h92, 8'h89};
    logic [7:0] astana [6] = '{8'h88, 8'h92, 8'h87, 8'h88, 8'hAB, 8'h88};
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.in_seg    = 8'hFF;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.in_ready), 32'd1);

    // TOMSK with a leading blank, terminated by last on beat 6
    for (int i = 0; i < 6; i++) beat(tomsk[i], i == 5);
    check_word("tomsk", 2'd1, 3'd5, 24'h975361, 1'b0);
    take("tomsk");

    // NSK with last, then three cycles of backpressure
    beat(8'hAB, 1'b0);
    beat(8'h92, 1'b0);
    beat(8'h89, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check_word("nsk_hold", 2'd2, 3'd3, 24'h999461, 1'b0);
      @(posedge clk);
      #1;
    end
    check_word("nsk_hold_end", 2'd2, 3'd3, 24'h999461, 1'b0);
    take("nsk");

    // Padded NSK ends on the sixth beat without last
    for (int i = 0; i < 6; i++) beat(nsk_pad[i], 1'b0);
    check_word("nsk_pad", 2'd2, 3'd3, 24'h999461, 1'b0);
    take("nsk_pad");

    // ASTANA, then a seventh beat offered while the word is held
    for (int i = 0; i < 6; i++) beat(astana[i], 1'b0);
    check_word("astana", 2'd3, 3'd6, 24'h067040, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_seg   = 8'h87;
    bus.in_last  = 1'b1;
    check("extra_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_word("astana_extra", 2'd3, 3'd6, 24'h067040, 1'b0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    take("astana");

    // Unknown pattern inside the word
    beat(8'h87, 1'b0);
    beat(8'h00, 1'b0);
    beat(8'h89, 1'b1);
    check_word("bad_pat", 2'd0, 3'd2, 24'h999971, 1'b1);
    take("bad_pat");

    // Blank between letters
    beat(8'hAB, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'h89, 1'b1);
    check_word("hole", 2'd0, 3'd2, 24'h999941, 1'b1);
    take("hole");

    // Reset in the middle of a word drops the partial TOMSK
    beat(8'h87, 1'b0);
    beat(8'hC0, 1'b0);
    check("partial_len", 32'(bus.out_len), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle("mid_reset");
    check("mid_reset_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    beat(8'hAB, 1'b0);
    beat(8'h92, 1'b0);
    beat(8'h89, 1'b1);
    check_word("post_reset_nsk", 2'd2, 3'd3, 24'h999461, 1'b0);
    take("post_reset_nsk");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_word_decoder.md
Name: seven_seg_word_decoder

Overview:
- Reverse of the board's letter-to-segment display path: takes a stream of 8-bit active-low seven-segment patterns (dp,g..a, one per digit, leftmost digit first) and decodes each back into a letter code.
- Assembles up to six digits into a word and classifies it as TOMSK, NSK, ASTANA or unknown.
- Used by self-checking display benches and the loopback demo that reads displayed patterns back.

Parameters:
- MAX_DIGITS, 6, digits per word; the beat with index MAX_DIGITS-1 always terminates the word.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  segment beat valid
- in_ready  output  1  decoder accepts a beat
- in_seg  input  8  active-low segment pattern, bit7 = dp
- in_last  input  1  final digit of the word
- out_valid  output  1  decoded word available
- out_ready  input  1  consumer takes the word
- out_word_id  output  2  0 unknown, 1 TOMSK, 2 NSK, 3 ASTANA
- out_len  output  3  number of letters, 0..6
- out_chars  output  24  six 4-bit letter codes, right-justified; last letter in [3:0]
- out_error  output  1  unknown pattern or blank inside the word

Behaviour:
- Letter codes and patterns (active-low):
  - A=0 (88h), K=1 (89h), L=2 (C7h), M=3 (EAh), N=4 (ABh), O=5 (C0h), S=6 (92h), T=7 (87h), Y=8 (91h).
  - BLANK=9 (FFh).
  - Any other pattern decodes to BAD=15.
- Two states, COLLECT and EMIT.
- COLLECT:
  - in_ready=1. A beat is accepted when in_valid&&in_ready.
  - Beat counter increments on every accepted beat, blanks included.
  - Leading blanks (before the first letter) are discarded and do not count toward out_len.
  - A letter shifts into the char register from the right, and len increments.
  - BLANK after a letter, or BAD anywhere, sets the sticky error flag. The beat still counts; nothing is shifted.
  - The word ends when the accepted beat has in_last=1 or is beat number MAX_DIGITS. On that beat, go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1. Outputs are registered: out_valid rises the cycle after the terminating beat.
  - Outputs stay stable while out_ready=0.
  - On out_valid&&out_ready, return to COLLECT and clear the counter, len, error and chars (chars to all BLANK, 999999h).
  - Back-to-back words therefore incur one bubble cycle.
- Classification is performed on entry to EMIT:
  - id=1 iff !error && len=5 && chars=9_7_5_3_6_1.
  - id=2 iff !error && len=3 && chars=999_4_6_1.
  - id=3 iff !error && len=6 && chars=0_6_7_0_4_0.
  - Otherwise id=0. An error always forces id=0.
- All-blank word: len=0, chars=999999h, error=0, id=0.
- Reset (async, any state, including mid-word):
  - state=COLLECT, in_ready=1 after deassertion.
  - out_valid=0, out_word_id=0, out_len=0, out_chars=999999h, out_error=0.
  - Counter cleared; the partial word is discarded.
- in_seg and in_last are ignored when in_valid=0 or in_ready=0.

Decomposition:
- Shared package seven_seg_pkg holds:
  - letter-code localparams and their segment-pattern constants (shared with the display encoders);
  - word-id constants;
  - the 24-bit reference words for TOMSK/NSK/ASTANA.
- Sub-module seven_seg_to_char: purely combinational, 8-bit pattern to 4-bit code including BAD. Reusable by other checkers.

Test Plan:
- TOMSK: FF,87,C0,EA,92,89 with last on the 6th beat -> one cycle later out_valid=1, id=1, len=5, chars=975361h, error=0.
- NSK: AB,92,89 with last on the 3rd beat -> id=2, len=3, chars=999461h. FF,FF,FF,AB,92,89 without last terminates at beat 6 with the same result.
- ASTANA: 88,92,87,88,AB,88 -> id=3, len=6, chars=067040h. A 7th beat offered during EMIT sees in_ready=0 and is not consumed.
- Errors:
  - 87,00,89 (last) -> error=1, id=0, len=2.
  - AB,FF,89 (last) -> error=1, id=0, len=2.
- Backpressure: hold out_ready=0 for 3 cycles after NSK -> out_* and out_valid constant, in_ready=0. out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Reset mid-word after 87,C0: assert reset -> outputs at reset values immediately. A following NSK word decodes as id=2 with no TOMSK residue.
